// File: rtl/ssg_field_ser_pkg.sv
// Shared defaults, field-length helper, FSM encodings and LFSR tap positions
// for the SIGNAL-field serializer.
package ssg_field_ser_pkg;

    localparam int DEF_TYPE_W = 4;
    localparam int DEF_LEN_W  = 12;
    localparam int DEF_TAIL_W = 6;
    localparam int DEF_SEED_W = 6;
    localparam logic [5:0] DEF_SEED_INIT = 6'h2D;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Tap positions counted down from the seed MSB: seed[W-1] ^ seed[W-2].
    localparam int LFSR_TAP_HI = 1;
    localparam int LFSR_TAP_LO = 2;

    function automatic int field_len(input int type_w, input int len_w, input int tail_w);
        return type_w + 1 + len_w + 1 + tail_w;
    endfunction

endpackage

// File: rtl/ssg_seed_lfsr.sv
// Per-frame scrambler seed generator: Fibonacci LFSR shifting left, advanced
// once per accepted frame, guarded so it can never start at or reach zero.
module ssg_seed_lfsr
    import ssg_field_ser_pkg::*;
#(
    parameter int                SEED_W    = DEF_SEED_W,
    parameter logic [SEED_W-1:0] SEED_INIT = DEF_SEED_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [SEED_W-1:0] seed_next
);

    localparam logic [SEED_W-1:0] INIT_FIX = (SEED_INIT == '0) ? SEED_W'(1) : SEED_INIT;

    logic [SEED_W-1:0] seed_q;
    logic [SEED_W-1:0] seed_d;
    logic [SEED_W-1:0] stepped;
    logic              feedback;

    always_comb begin
        feedback  = seed_q[SEED_W-LFSR_TAP_HI] ^ seed_q[SEED_W-LFSR_TAP_LO];
        stepped   = {seed_q[SEED_W-2:0], feedback};
        seed_next = (stepped == '0) ? SEED_W'(1) : stepped;
        seed_d    = adv ? seed_next : seed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q <= INIT_FIX;
        end else begin
            seed_q <= seed_d;
        end
    end

endmodule

// File: rtl/ssg_field_ser.sv
// SIGNAL-field serializer: accepts a type/length descriptor and emits
// type, reserved, length, even parity and a zero tail LSB-first with backpressure.
module ssg_field_ser
    import ssg_field_ser_pkg::*;
#(
    parameter int                TYPE_W    = DEF_TYPE_W,
    parameter int                LEN_W     = DEF_LEN_W,
    parameter int                TAIL_W    = DEF_TAIL_W,
    parameter int                SEED_W    = DEF_SEED_W,
    parameter logic [SEED_W-1:0] SEED_INIT = DEF_SEED_INIT
) (
    input  logic              ssg_clk,
    input  logic              ssg_rst,
    input  logic [TYPE_W-1:0] ssg_di_type,
    input  logic [LEN_W-1:0]  ssg_di_len,
    input  logic              ssg_di_vld,
    output logic              ssg_di_rdy,
    output logic              ssg_do,
    output logic              ssg_do_vld,
    input  logic              ssg_do_rdy,
    output logic              ssg_do_last,
    output logic [SEED_W-1:0] ssg_do_init,
    output logic              ssg_err
);

    localparam int N     = field_len(TYPE_W, LEN_W, TAIL_W);
    localparam int CNT_W = $clog2(N + 1);

    logic [0:0]        state_q, state_d;
    logic [N-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEED_W-1:0] init_q, init_d;
    logic              err_q, err_d;
    logic              seed_adv;
    logic [SEED_W-1:0] seed_next;
    logic              parity;

    ssg_seed_lfsr #(
        .SEED_W   (SEED_W),
        .SEED_INIT(SEED_INIT)
    ) u_seed (
        .clk      (ssg_clk),
        .rst      (ssg_rst),
        .adv      (seed_adv),
        .seed_next(seed_next)
    );

    assign parity      = (^ssg_di_type) ^ (^ssg_di_len);
    assign ssg_di_rdy  = (state_q == ST_IDLE) && !ssg_rst;
    assign ssg_do_vld  = (state_q == ST_SHIFT);
    assign ssg_do      = ssg_do_vld & shreg_q[0];
    assign ssg_do_last = ssg_do_vld && (cnt_q == CNT_W'(N - 1));
    assign ssg_do_init = init_q;
    assign ssg_err     = err_q;

    // Zero-length descriptors are consumed but produce only an error pulse.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
        err_d    = 1'b0;
        seed_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ssg_di_vld) begin
                    if (ssg_di_len != '0) begin
                        shreg_d  = {{TAIL_W{1'b0}}, parity, ssg_di_len, 1'b0, ssg_di_type};
                        cnt_d    = '0;
                        seed_adv = 1'b1;
                        init_d   = seed_next;
                        state_d  = ST_SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (ssg_do_rdy) begin
                    shreg_d = {1'b0, shreg_q[N-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (ssg_do_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ssg_clk) begin
        if (ssg_rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            init_q  <= SEED_INIT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ssg_field_ser.sv
// Self-checking bench for ssg_field_ser: directed and randomized frames checked
// against a bit-level field model and an arithmetic seed-sequence model.
module tb_ssg_field_ser;

    localparam int N = 24;

    logic        ssg_clk = 1'b0;
    logic        ssg_rst = 1'b1;
    logic [3:0]  ssg_di_type = '0;
    logic [11:0] ssg_di_len = '0;
    logic        ssg_di_vld = 1'b0;
    logic        ssg_di_rdy;
    logic        ssg_do;
    logic        ssg_do_vld;
    logic        ssg_do_rdy = 1'b1;
    logic        ssg_do_last;
    logic [5:0]  ssg_do_init;
    logic        ssg_err;

    int          total = 0;
    int          fails = 0;
    logic [5:0]  model_seed;
    logic [N-1:0] obs_vec;
    int          busy_cycles;
    int          stall_cycles;
    logic [5:0]  seeds [64];

    ssg_field_ser dut (
        .ssg_clk    (ssg_clk),
        .ssg_rst    (ssg_rst),
        .ssg_di_type(ssg_di_type),
        .ssg_di_len (ssg_di_len),
        .ssg_di_vld (ssg_di_vld),
        .ssg_di_rdy (ssg_di_rdy),
        .ssg_do     (ssg_do),
        .ssg_do_vld (ssg_do_vld),
        .ssg_do_rdy (ssg_do_rdy),
        .ssg_do_last(ssg_do_last),
        .ssg_do_init(ssg_do_init),
        .ssg_err    (ssg_err)
    );

    always #5 ssg_clk = ~ssg_clk;

    // Next seed of x^6+x^5+1, computed from bit values with integer arithmetic.
    function automatic logic [5:0] next_seed(input logic [5:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = (((v / 32) % 2) + ((v / 16) % 2)) % 2;
        return 6'(((v * 2) % 64) + fb);
    endfunction

    // Wire-order bit i of the field for a given descriptor.
    function automatic int exp_bit(input logic [3:0] typ, input logic [11:0] len, input int i);
        if (i < 4)   return (int'(typ) >> i) % 2;
        if (i == 4)  return 0;
        if (i < 17)  return (int'(len) >> (i - 5)) % 2;
        if (i == 17) return ($countones(typ) + $countones(len)) % 2;
        return 0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the block is idle again.
    task automatic run_frame(input logic [3:0] typ, input logic [11:0] len, input bit stall);
        int idx;
        bit go;
        idx = 0;
        busy_cycles = 0;
        stall_cycles = 0;
        obs_vec = '0;
        check_output("accept_rdy", 32'(ssg_di_rdy), 32'd1);
        ssg_di_type = typ;
        ssg_di_len  = len;
        ssg_di_vld  = 1'b1;
        model_seed  = next_seed(model_seed);
        @(negedge ssg_clk);
        ssg_di_vld  = 1'b0;
        ssg_di_type = 4'($urandom);
        ssg_di_len  = 12'($urandom);
        check_output("init_seed", 32'(ssg_do_init), 32'(model_seed));
        while (ssg_di_rdy !== 1'b1 && busy_cycles < 400) begin
            busy_cycles++;
            check_output("do_vld", 32'(ssg_do_vld), 32'd1);
            if (idx < N) begin
                check_output("do_bit", 32'(ssg_do), 32'(exp_bit(typ, len, idx)));
                check_output("do_last", 32'(ssg_do_last), 32'(idx == N - 1));
                obs_vec[idx] = ssg_do;
            end
            go = stall ? bit'($urandom_range(0, 1)) : 1'b1;
            ssg_do_rdy = go;
            if (go) idx++;
            else stall_cycles++;
            @(negedge ssg_clk);
        end
        ssg_do_rdy = 1'b1;
        check_output("bits_sent", 32'(idx), 32'(N));
        check_output("busy_cycles", 32'(busy_cycles), 32'(N + stall_cycles));
        check_output("vld_after", 32'(ssg_do_vld), 32'd0);
        check_output("init_hold", 32'(ssg_do_init), 32'(model_seed));
    endtask

    task automatic applyStimulus;
        int err_count;
        int repeats;
        int zeros;

        // Reset state
        repeat (3) @(negedge ssg_clk);
        check_output("rst_rdy_low", 32'(ssg_di_rdy), 32'd0);
        check_output("rst_vld", 32'(ssg_do_vld), 32'd0);
        ssg_rst = 1'b0;
        @(negedge ssg_clk);
        check_output("post_rst_rdy", 32'(ssg_di_rdy), 32'd1);
        check_output("post_rst_do", 32'(ssg_do), 32'd0);
        check_output("post_rst_last", 32'(ssg_do_last), 32'd0);
        check_output("post_rst_err", 32'(ssg_err), 32'd0);
        check_output("post_rst_init", 32'(ssg_do_init), 32'h2D);
        model_seed = 6'h2D;

        // Basic frame
        run_frame(4'b1011, 12'd100, 1'b0);
        check_output("basic_vec", 32'(obs_vec), 32'h000C8B);
        check_output("basic_seed", 32'(ssg_do_init), 32'h1B);

        // Parity corner cases
        run_frame(4'b0001, 12'd2, 1'b0);
        check_output("par_1_2", 32'(obs_vec[17]), 32'd0);
        run_frame(4'b0001, 12'd1, 1'b0);
        check_output("par_1_1", 32'(obs_vec[17]), 32'd0);
        run_frame(4'b0011, 12'd1, 1'b0);
        check_output("par_3_1", 32'(obs_vec[17]), 32'd1);

        // Backpressure
        run_frame(4'b1011, 12'd100, 1'b1);
        check_output("stall_vec", 32'(obs_vec), 32'h000C8B);
        $display("[TB] backpressure frame took %0d cycles with %0d stalls", busy_cycles, stall_cycles);

        // Zero-length descriptor
        ssg_di_type = 4'($urandom);
        ssg_di_len  = 12'd0;
        ssg_di_vld  = 1'b1;
        @(negedge ssg_clk);
        ssg_di_vld = 1'b0;
        err_count = 0;
        if (ssg_err === 1'b1) err_count++;
        check_output("zero_vld", 32'(ssg_do_vld), 32'd0);
        repeat (3) begin
            @(negedge ssg_clk);
            if (ssg_err === 1'b1) err_count++;
            check_output("zero_vld_idle", 32'(ssg_do_vld), 32'd0);
        end
        check_output("zero_err_pulses", 32'(err_count), 32'd1);
        check_output("zero_rdy", 32'(ssg_di_rdy), 32'd1);
        run_frame(4'($urandom), 12'($urandom_range(1, 4095)), 1'b0);

        // Seed sequence over 64 back-to-back frames
        for (int f = 0; f < 64; f++) begin
            run_frame(4'($urandom), 12'($urandom_range(1, 4095)), 1'b0);
            seeds[f] = ssg_do_init;
        end
        repeats = 0;
        zeros = 0;
        for (int i = 0; i < 64; i++) begin
            if (seeds[i] == 6'd0) zeros++;
            if (i > 0 && i < 63 && seeds[i] == seeds[0]) repeats++;
        end
        check_output("seed_nonzero", 32'(zeros), 32'd0);
        check_output("seed_no_early_repeat", 32'(repeats), 32'd0);
        check_output("seed_wrap_64", 32'(seeds[63]), 32'(seeds[0]));

        // Reset in mid-frame
        ssg_di_type = 4'b0110;
        ssg_di_len  = 12'd777;
        ssg_di_vld  = 1'b1;
        @(negedge ssg_clk);
        ssg_di_vld = 1'b0;
        repeat (10) @(negedge ssg_clk);
        check_output("mid_vld_before", 32'(ssg_do_vld), 32'd1);
        ssg_rst = 1'b1;
        @(negedge ssg_clk);
        check_output("mid_rdy", 32'(ssg_di_rdy), 32'd0);
        check_output("mid_vld", 32'(ssg_do_vld), 32'd0);
        check_output("mid_do", 32'(ssg_do), 32'd0);
        check_output("mid_last", 32'(ssg_do_last), 32'd0);
        check_output("mid_init", 32'(ssg_do_init), 32'h2D);
        @(negedge ssg_clk);
        ssg_rst = 1'b0;
        @(negedge ssg_clk);
        check_output("mid_post_rdy", 32'(ssg_di_rdy), 32'd1);
        check_output("mid_post_vld", 32'(ssg_do_vld), 32'd0);
        model_seed = 6'h2D;
        run_frame(4'b1011, 12'd100, 1'b0);
        check_output("mid_new_vec", 32'(obs_vec), 32'h000C8B);
        check_output("mid_new_seed", 32'(ssg_do_init), 32'h1B);
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
